hazard_stall_unit: RTL

- Pipeline control block that reads the stage fields of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Drives the write-enable and flush/bubble controls back into those registers and the PC.
- Handles three cases: load-use stalls, taken-branch flushes, and whole-pipeline freezes while a multi-cycle data-memory access completes.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

---
 rtl/hazard_stall_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// whole-pipe freezes while a multi-cycle data-memory access completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; stalls/flushes decided per cycle
// MEM_WAIT | data memory busy; pipe frozen until mem_ready
module hazard_stall_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rn,
  input  logic [4:0]       ID_Rm,
  input  logic             ID_uses_Rn,
  input  logic             ID_uses_Rm,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Write_Reg,
  input  logic             branch_taken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             mem_ready,
  output logic             PC_wr_en,
  output logic             IF_ID_wr_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_pending;
  logic              load_use;

  assign mem_pending = (MEM_MemRead | MEM_MemWrite) & ~mem_ready;

  // XZR (r31) reads as zero, so a load targeting it can never create a hazard
  assign load_use = EX_MemRead && (EX_Write_Reg != 5'd31) &&
                    ((ID_uses_Rn && (ID_Rn == EX_Write_Reg)) ||
                     (ID_uses_Rm && (ID_Rm == EX_Write_Reg)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      flush_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!PC_wr_en && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (IF_ID_flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
      if ((state_nxt == MEM_WAIT) && (wait_nxt >= WAIT_MAX))
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_pending) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready)
          state_nxt = RUN;
        else if (wait_cnt != WAIT_MAX)
          wait_nxt = wait_cnt + 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs stay at their pass-through values while reset is held low
  always_comb begin
    PC_wr_en     = 1'b1;
    IF_ID_wr_en  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (mem_pending) begin
            pipe_freeze = 1'b1;
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
          end else if (load_use) begin
            PC_wr_en     = 1'b0;
            IF_ID_wr_en  = 1'b0;
            ID_EX_bubble = 1'b1;
          end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pipe_freeze = 1'b1;
          PC_wr_en    = 1'b0;
          IF_ID_wr_en = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
